// File: rtl/baud_gen_frac_if.sv
// baud_gen_frac_if -- control and tick bundle for the fractional baud generator.
//
// Compile-time option: BAUD_CUSTOM_DIV_EN adds the custom_div field and the
// DIV_W / FRAC_W parameters that size it.
//
// Signals:
//   enable      master->slave  1 = advance the generator, 0 = hold
//   sync_clear  master->slave  synchronous phase restart
//   baud_sel    master->slave  rate select (3 bits)
//   custom_div  master->slave  Q(DIV_W).(FRAC_W) divisor, option only
//   os_tick     slave->master  oversample strobe
//   mid_tick    slave->master  mid-bit strobe
//   bit_tick    slave->master  end-of-bit strobe
//
// There is no valid/ready handshake on this bundle: controls are levels
// sampled on every rising clk edge, and each tick is a registered strobe
// that is meaningful on the single cycle it is high (no back-pressure).
interface baud_gen_frac_if
`ifdef BAUD_CUSTOM_DIV_EN
  #(
    parameter int DIV_W  = 12,
    parameter int FRAC_W = 4
  )
`endif
  ;
  logic       enable;
  logic       sync_clear;
  logic [2:0] baud_sel;
`ifdef BAUD_CUSTOM_DIV_EN
  logic [DIV_W+FRAC_W-1:0] custom_div;
`endif
  logic       os_tick;
  logic       mid_tick;
  logic       bit_tick;

`ifdef BAUD_CUSTOM_DIV_EN
  modport master (output enable, sync_clear, baud_sel, custom_div,
                  input  os_tick, mid_tick, bit_tick);
  modport slave  (input  enable, sync_clear, baud_sel, custom_div,
                  output os_tick, mid_tick, bit_tick);
`else
  modport master (output enable, sync_clear, baud_sel,
                  input  os_tick, mid_tick, bit_tick);
  modport slave  (input  enable, sync_clear, baud_sel,
                  output os_tick, mid_tick, bit_tick);
`endif
endinterface

// File: rtl/baud_gen_frac.sv
// baud_gen_frac -- fractional baud-tick generator shared by UART Tx and Rx.
//
// A phase accumulator adds 2^FRAC_W every enabled cycle and subtracts the
// divisor D (unsigned Q(DIV_W).(FRAC_W)) each time it wraps, so the long-term
// os_tick rate is exactly clk * 2^FRAC_W / D even for non-integer divisors.
// Sixteen (OVERSAMPLE) os_ticks make one bit; mid_tick marks the middle os_tick
// of each bit and bit_tick the last. All ticks are registered.
//
// Compile-time option: BAUD_CUSTOM_DIV_EN enables baud_sel=6 to take its
// divisor from the custom_div field of the bus.
//
// Ports:
//   clk     in   system clock, rising edge
//   resetn  in   asynchronous active-low reset
//   bus     slave modport of baud_gen_frac_if (enable, sync_clear, baud_sel,
//           [custom_div], os_tick, mid_tick, bit_tick)
module baud_gen_frac #(
  parameter int CLK_HZ     = 36_000_000,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_W      = 12,
  parameter int FRAC_W     = 4
) (
  input  logic            clk,
  input  logic            resetn,
  baud_gen_frac_if.slave  bus
);

  localparam int ACC_W = DIV_W + FRAC_W;
  localparam int CNT_W = $clog2(OVERSAMPLE);

  // One clk worth of phase; also the smallest legal divisor.
  localparam logic [ACC_W-1:0] D_MIN = ACC_W'(2 ** FRAC_W);
  localparam logic [ACC_W-1:0] D_MAX = '1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OVERSAMPLE / 2 - 1);

  // round-half-up(CLK_HZ * 2^FRAC_W / (baud * OVERSAMPLE)), clamped to range.
  function automatic logic [ACC_W-1:0] preset_div(input longint baud);
    longint num;
    longint den;
    longint q;
    num = longint'(CLK_HZ) << FRAC_W;
    den = baud * longint'(OVERSAMPLE);
    q   = (2 * num + den) / (2 * den);
    if (q < longint'(D_MIN)) q = longint'(D_MIN);
    if (q > longint'(D_MAX)) q = longint'(D_MAX);
    return q[ACC_W-1:0];
  endfunction

  localparam logic [ACC_W-1:0] D_4800   = preset_div(4800);
  localparam logic [ACC_W-1:0] D_9600   = preset_div(9600);
  localparam logic [ACC_W-1:0] D_19200  = preset_div(19200);
  localparam logic [ACC_W-1:0] D_38400  = preset_div(38400);
  localparam logic [ACC_W-1:0] D_57600  = preset_div(57600);
  localparam logic [ACC_W-1:0] D_115200 = preset_div(115200);

  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] os_cnt;
  logic [ACC_W-1:0] div_q;
  logic             os_tick_q;
  logic             mid_tick_q;
  logic             bit_tick_q;

  logic [ACC_W-1:0] raw_d;
  logic [ACC_W-1:0] dec_d;
  logic [ACC_W:0]   nxt;
  logic [ACC_W-1:0] acc_sub;
  logic             hit;
  logic             restart;

  // Rate decode. Reserved codes (and 6 without the custom option) fall back
  // to the 4800 preset.
  always_comb begin
    raw_d = D_4800;
    case (bus.baud_sel)
      3'd1:    raw_d = D_9600;
      3'd2:    raw_d = D_19200;
      3'd3:    raw_d = D_38400;
      3'd4:    raw_d = D_57600;
      3'd5:    raw_d = D_115200;
`ifdef BAUD_CUSTOM_DIV_EN
      3'd6:    raw_d = bus.custom_div;
`endif
      default: raw_d = D_4800;
    endcase
    dec_d = (raw_d < D_MIN) ? D_MIN : raw_d;
  end

  // nxt is one bit wider so the add can never wrap. When it reaches div_q the
  // true difference is below 2^FRAC_W, so an ACC_W-bit subtraction is exact.
  assign nxt     = {1'b0, acc} + {1'b0, D_MIN};
  assign hit     = (nxt >= {1'b0, div_q});
  assign acc_sub = nxt[ACC_W-1:0] - div_q;

  // Any change of the decoded divisor restarts the phase, just like sync_clear,
  // so a rate switch never leaves a stale fractional phase behind.
  assign restart = bus.sync_clear | (dec_d != div_q);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      acc        <= '0;
      os_cnt     <= '0;
      div_q      <= D_4800;
      os_tick_q  <= 1'b0;
      mid_tick_q <= 1'b0;
      bit_tick_q <= 1'b0;
    end else if (restart) begin
      acc        <= '0;
      os_cnt     <= '0;
      div_q      <= dec_d;
      os_tick_q  <= 1'b0;
      mid_tick_q <= 1'b0;
      bit_tick_q <= 1'b0;
    end else if (bus.enable) begin
      if (hit) begin
        acc        <= acc_sub;
        os_tick_q  <= 1'b1;
        // Decoded from os_cnt before it advances, so they coincide with os_tick.
        mid_tick_q <= (os_cnt == CNT_MID);
        bit_tick_q <= (os_cnt == CNT_LAST);
        os_cnt     <= (os_cnt == CNT_LAST) ? '0 : os_cnt + 1'b1;
      end else begin
        acc        <= nxt[ACC_W-1:0];
        os_tick_q  <= 1'b0;
        mid_tick_q <= 1'b0;
        bit_tick_q <= 1'b0;
      end
    end else begin
      os_tick_q  <= 1'b0;
      mid_tick_q <= 1'b0;
      bit_tick_q <= 1'b0;
    end
  end

  assign bus.os_tick  = os_tick_q;
  assign bus.mid_tick = mid_tick_q;
  assign bus.bit_tick = bit_tick_q;

endmodule

// File: tb/tb_baud_gen_frac.sv
// tb_baud_gen_frac -- directed bench for baud_gen_frac at default parameters.
// Tick times are logged against a posedge counter; expected times are
// hand-computed from the divisor presets (7500, 938, 313, custom 16/40).
module tb_baud_gen_frac;

  localparam int CLK_PERIOD = 10;
  localparam int T_OS  = 0;
  localparam int T_MID = 1;
  localparam int T_BIT = 2;

  // ---------------- clock / reset ----------------
  logic clk    = 1'b0;
  logic resetn = 1'b0;
  int   cyc    = 0;

  always #(CLK_PERIOD / 2) clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

`ifdef BAUD_CUSTOM_DIV_EN
  baud_gen_frac_if #(.DIV_W(12), .FRAC_W(4)) bif ();
`else
  baud_gen_frac_if bif ();
`endif

  baud_gen_frac dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bif)
  );

  // ---------------- tick logs / scoreboard ----------------
  int          os_log[$];
  int          mid_log[$];
  int          bit_log[$];
  logic [31:0] exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  always @(negedge clk) begin
    if (bif.os_tick  === 1'b1) os_log.push_back(cyc);
    if (bif.mid_tick === 1'b1) mid_log.push_back(cyc);
    if (bif.bit_tick === 1'b1) bit_log.push_back(cyc);
  end

  function automatic int log_len(input int kind);
    return (kind == T_OS) ? os_log.size() : (kind == T_MID) ? mid_log.size() : bit_log.size();
  endfunction

  function automatic int log_at(input int kind, input int i);
    return (kind == T_OS) ? os_log[i] : (kind == T_MID) ? mid_log[i] : bit_log[i];
  endfunction

  // Time of the n-th (1-based) tick of a kind at or after cycle t; -1 if none.
  function automatic int nth_after(input int kind, input int t, input int n);
    int seen = 0;
    for (int i = 0; i < log_len(kind); i++) begin
      if (log_at(kind, i) >= t) begin
        seen++;
        if (seen == n) return log_at(kind, i);
      end
    end
    return -1;
  endfunction

  function automatic int count_in(input int kind, input int t1, input int t2);
    int n = 0;
    for (int i = 0; i < log_len(kind); i++)
      if (log_at(kind, i) >= t1 && log_at(kind, i) <= t2) n++;
    return n;
  endfunction

  task automatic check(input string tag, input int obs, input int want);
    n_tests++;
    if (obs !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, want);
    end
  endtask

  // Drains exp_q against successive ticks of one kind starting at t_from.
  task automatic score(input string tag, input int kind, input int t_from);
    int idx = 1;
    while (exp_q.size() > 0) begin
      logic [31:0] want;
      want = exp_q.pop_front();
      check($sformatf("%s_%0d", tag, idx), nth_after(kind, t_from, idx), int'(want));
      idx++;
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #(CLK_PERIOD * 90000);
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int t0;
    int r;
    int s;
    int c;
    int bad;
    int g;
    int found;

    bif.enable     = 1'b1;
    bif.sync_clear = 1'b0;
    bif.baud_sel   = 3'd0;
`ifdef BAUD_CUSTOM_DIV_EN
    bif.custom_div = '0;
`endif

    // Reset state.
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_os",  int'(bif.os_tick),  0);
    check("rst_mid", int'(bif.mid_tick), 0);
    check("rst_bit", int'(bif.bit_tick), 0);

    // Test 1: sel 0 (D=7500) from reset release.
    t0 = cyc;
    resetn = 1'b1;
    repeat (18770) @(negedge clk);
    check("t1_first_os", nth_after(T_OS, t0 + 1, 1), t0 + 469);
    check("t1_os_gap", nth_after(T_OS, t0 + 1, 2) - nth_after(T_OS, t0 + 1, 1), 469);
    check("t1_4os_span", nth_after(T_OS, t0 + 1, 5) - nth_after(T_OS, t0 + 1, 1), 1875);
    bad = 0;
    for (int i = 1; i <= 16; i++) begin
      g = nth_after(T_OS, t0 + 1, i + 1) - nth_after(T_OS, t0 + 1, i);
      if (g != 468 && g != 469) bad++;
    end
    check("t1_gaps_468_469", bad, 0);
    exp_q.push_back(32'(t0 + 7500));
    exp_q.push_back(32'(t0 + 15000));
    score("t1_bit", T_BIT, t0 + 1);
    check("t1_mid_1", nth_after(T_MID, t0 + 1, 1), t0 + 3750);
    check("t1_mid_2", nth_after(T_MID, t0 + 1, 2), t0 + 11250);

    // Test 2: switch to sel 3 (D=938) mid-bit; restart at edge r.
    c = cyc;
    bif.baud_sel = 3'd3;
    r = c + 1;
    repeat (2000) @(negedge clk);
    check("t2_first_os", nth_after(T_OS, r + 1, 1), r + 59);
    exp_q.push_back(32'(r + 938));
    exp_q.push_back(32'(r + 1876));
    score("t2_bit", T_BIT, r + 1);
    check("t2_os_per_bit",
          count_in(T_OS, nth_after(T_BIT, r + 1, 1) + 1, nth_after(T_BIT, r + 1, 2)), 16);
    bad = 0;
    for (int i = 1; i <= 16; i++) begin
      g = nth_after(T_OS, r + 1, i + 1) - nth_after(T_OS, r + 1, i);
      if (g != 58 && g != 59) bad++;
    end
    check("t2_gaps_58_59", bad, 0);

    // Test 3: back to sel 0, then sync_clear on the edge that would carry the
    // 8th os_tick (and a mid_tick).
    c = cyc;
    bif.baud_sel = 3'd0;
    r = c + 1;
    repeat (3750) @(negedge clk);
    bif.sync_clear = 1'b1;
    @(negedge clk);
    bif.sync_clear = 1'b0;
    s = cyc;
    check("t3_clr_edge", s, r + 3750);
    check("t3_clr_os",  int'(bif.os_tick),  0);
    check("t3_clr_mid", int'(bif.mid_tick), 0);

    // Test 4a: enable low for 100 edges (s+8001..s+8100) inside the second bit.
    repeat (8000) @(negedge clk);
    bif.enable = 1'b0;
    repeat (100) @(negedge clk);
    bif.enable = 1'b1;
    repeat (7010) @(negedge clk);
    check("t3_first_os", nth_after(T_OS, s + 1, 1), s + 469);
    check("t3_mid_8th",  nth_after(T_MID, s + 1, 1), s + 3750);
    check("t4_pause_os", count_in(T_OS, s + 8001, s + 8100), 0);
    check("t4_mid_shift", nth_after(T_MID, s + 1, 2), s + 11350);
    exp_q.push_back(32'(s + 7500));
    exp_q.push_back(32'(s + 15100));
    score("t34_bit", T_BIT, s + 1);

    // Test 4b: sel 0 -> 5 (D=313) mid-bit; 16 bits in exactly 5008 cycles.
    c = cyc;
    bif.baud_sel = 3'd5;
    r = c + 1;
    repeat (5100) @(negedge clk);
    check("t4_sel5_first_os", nth_after(T_OS, r + 1, 1), r + 20);
    for (int m = 1; m <= 16; m++) exp_q.push_back(32'(r + 313 * m));
    score("t4_sel5_bit", T_BIT, r + 1);

    // Test 5: async reset drop while bit_tick is high.
    found = 0;
    for (int i = 0; i < 400 && found == 0; i++) begin
      @(negedge clk);
      if (bif.bit_tick === 1'b1) found = 1;
    end
    check("t5_bit_seen", found, 1);
    #1 resetn = 1'b0;
    #1;
    check("t5_async_os",  int'(bif.os_tick),  0);
    check("t5_async_mid", int'(bif.mid_tick), 0);
    check("t5_async_bit", int'(bif.bit_tick), 0);
    bif.baud_sel = 3'd0;
    repeat (3) @(negedge clk);
    check("t5_hold_os", int'(bif.os_tick), 0);
    t0 = cyc;
    resetn = 1'b1;
    // Reserved code 7 decodes as sel 0, so it must not restart the phase.
    repeat (100) @(negedge clk);
    bif.baud_sel = 3'd7;
    repeat (7420) @(negedge clk);
    check("t5_first_os", nth_after(T_OS,  t0 + 1, 1), t0 + 469);
    check("t5_mid",      nth_after(T_MID, t0 + 1, 1), t0 + 3750);
    check("t5_bit",      nth_after(T_BIT, t0 + 1, 1), t0 + 7500);

`ifdef BAUD_CUSTOM_DIV_EN
    // Test 6: custom divisors.
    c = cyc;
    bif.custom_div = 16'd16;
    bif.baud_sel   = 3'd6;
    r = c + 1;
    repeat (100) @(negedge clk);
    check("t6_d16_os_cont", count_in(T_OS, r + 1, r + 64), 64);
    check("t6_d16_bit_1", nth_after(T_BIT, r + 1, 1), r + 16);
    check("t6_d16_bit_2", nth_after(T_BIT, r + 1, 2), r + 32);
    c = cyc;
    bif.custom_div = 16'd0;
    repeat (100) @(negedge clk);
    check("t6_d0_os_cont", count_in(T_OS, c + 1, c + 64), 64);
    check("t6_d0_bit_gap", nth_after(T_BIT, c + 1, 2) - nth_after(T_BIT, c + 1, 1), 16);
    c = cyc;
    bif.custom_div = 16'd40;
    r = c + 1;
    repeat (200) @(negedge clk);
    check("t6_d40_bit_1", nth_after(T_BIT, r + 1, 1), r + 40);
    check("t6_d40_bit_2", nth_after(T_BIT, r + 1, 2), r + 80);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
